// File: rtl/fir_mac_serial.sv
// Serial FIR engine: snapshots the tap line on start and accumulates one
// tap*coeff product per clock through a single shared multiplier.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for i_start_calc; o_busy low
//   CALC  | accumulating snap[index]*coeff[index], one tap per clock
module fir_mac_serial #(
   parameter int TOTAL_TAPS   = 9,
   parameter int BITS_PER_TAP = 8,
   parameter int COEFF_BITS   = 8,
   parameter int TOTAL_BITS   = TOTAL_TAPS*BITS_PER_TAP,
   parameter int ACC_BITS     = BITS_PER_TAP+COEFF_BITS+$clog2(TOTAL_TAPS)
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           i_start_calc,
   input  logic [TOTAL_BITS-1:0]          i_taps,
   input  logic [TOTAL_TAPS*COEFF_BITS-1:0] i_coeffs,
   output logic [ACC_BITS-1:0]            o_value,
   output logic                           o_valid,
   output logic                           o_busy,
   output logic                           o_overrun
);

   localparam int IDX_BITS  = (TOTAL_TAPS > 1) ? $clog2(TOTAL_TAPS) : 1;
   localparam int PROD_BITS = BITS_PER_TAP + COEFF_BITS;
   localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(TOTAL_TAPS-1);

   typedef enum logic {IDLE, CALC} state_t;

   state_t                  state, state_next;
   logic [IDX_BITS-1:0]     index, index_next;
   logic [ACC_BITS-1:0]     acc, acc_next, acc_sum;
   logic [TOTAL_BITS-1:0]   snap, snap_next;
   logic [ACC_BITS-1:0]     value_next;
   logic                    valid_next;
   logic                    overrun_next;

   logic signed [BITS_PER_TAP-1:0] tap_cur;
   logic signed [COEFF_BITS-1:0]   coeff_cur;
   logic signed [PROD_BITS-1:0]    prod;
   logic [ACC_BITS-1:0]            prod_ext;

   // Coefficients are read live; only the taps are frozen in the snapshot.
   assign tap_cur   = snap[index*BITS_PER_TAP +: BITS_PER_TAP];
   assign coeff_cur = i_coeffs[index*COEFF_BITS +: COEFF_BITS];
   assign prod      = tap_cur * coeff_cur;
   assign prod_ext  = {{(ACC_BITS-PROD_BITS){prod[PROD_BITS-1]}}, prod};
   assign acc_sum   = acc + prod_ext;
   assign o_busy    = (state == CALC);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         index     <= '0;
         acc       <= '0;
         snap      <= '0;
         o_value   <= '0;
         o_valid   <= 1'b0;
         o_overrun <= 1'b0;
      end else begin
         state     <= state_next;
         index     <= index_next;
         acc       <= acc_next;
         snap      <= snap_next;
         o_value   <= value_next;
         o_valid   <= valid_next;
         o_overrun <= overrun_next;
      end
   end

   always_comb begin
      state_next   = state;
      index_next   = index;
      acc_next     = acc;
      snap_next    = snap;
      value_next   = o_value;
      valid_next   = 1'b0;
      overrun_next = o_overrun;
      case (state)
         IDLE: begin
            if (i_start_calc) begin
               snap_next  = i_taps;
               acc_next   = '0;
               index_next = '0;
               state_next = CALC;
            end
         end
         CALC: begin
            if (i_start_calc) overrun_next = 1'b1;
            acc_next = acc_sum;
            if (index == LAST_IDX) begin
               value_next = acc_sum;
               valid_next = 1'b1;
               index_next = '0;
               state_next = IDLE;
            end else begin
               index_next = index + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_fir_mac_serial.sv
// Directed bench for fir_mac_serial: latency, arithmetic corners, snapshot,
// overrun, back-to-back starts and reset abort.
module tb_fir_mac_serial;

   localparam int TAPS = 9;
   localparam int TB_W = 8;
   localparam int CB_W = 8;
   localparam int ACC  = 20;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 i_start_calc;
   logic [TAPS*TB_W-1:0] i_taps;
   logic [TAPS*CB_W-1:0] i_coeffs;
   logic [ACC-1:0]       o_value;
   logic                 o_valid;
   logic                 o_busy;
   logic                 o_overrun;

   int tests = 0;
   int fails = 0;

   fir_mac_serial dut (
      .clk          (clk),
      .reset        (reset),
      .i_start_calc (i_start_calc),
      .i_taps       (i_taps),
      .i_coeffs     (i_coeffs),
      .o_value      (o_value),
      .o_valid      (o_valid),
      .o_busy       (o_busy),
      .o_overrun    (o_overrun)
   );

   always #5 clk = ~clk;

   function automatic logic [TAPS*8-1:0] fill(input logic [7:0] v);
      logic [TAPS*8-1:0] r;
      for (int k = 0; k < TAPS; k++) r[k*8 +: 8] = v;
      return r;
   endfunction

   function automatic logic [TAPS*8-1:0] ramp(input int offset);
      logic [TAPS*8-1:0] r;
      for (int k = 0; k < TAPS; k++) r[k*8 +: 8] = 8'(k + offset);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_pulse();
      i_start_calc = 1'b1;
      tick();
      i_start_calc = 1'b0;
   endtask

   // Ticks until o_valid is seen or the budget runs out; lat=0 on timeout.
   task automatic wait_valid(input int budget, output int lat, output int busy_n);
      int i;
      lat = 0;
      busy_n = 0;
      i = 0;
      while (lat == 0 && i < budget) begin
         tick();
         i++;
         if (o_valid) lat = i;
         else if (o_busy) busy_n++;
      end
   endtask

   task automatic test_reset();
      int lat, bn;
      reset = 1'b1;
      i_start_calc = 1'b1;
      i_taps = fill(8'd1);
      i_coeffs = fill(8'd1);
      for (int c = 0; c < 2; c++) begin
         tick();
         tests++;
         if ({o_value, o_valid, o_busy, o_overrun} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: value=%0d valid=%b busy=%b overrun=%b, want all 0",
                     $signed(o_value), o_valid, o_busy, o_overrun);
         end
      end
      reset = 1'b0;
      i_start_calc = 1'b0;
      tick();
      start_pulse();
      wait_valid(20, lat, bn);
      tests++;
      if (lat !== 9 || o_value !== 20'd9) begin
         fails++;
         $display("FAIL reset_first_start: lat=%0d value=%0d, want lat=9 value=9", lat, $signed(o_value));
      end
   endtask

   task automatic test_impulse();
      int lat, bn;
      i_coeffs = ramp(1);
      i_taps = '0;
      i_taps[7:0] = 8'd1;
      start_pulse();
      tests++;
      if (o_busy !== 1'b1) begin
         fails++;
         $display("FAIL impulse_busy_rise: busy=%b, want 1", o_busy);
      end
      wait_valid(20, lat, bn);
      tests++;
      if (lat !== 9 || bn !== 8 || o_value !== 20'd1 || o_busy !== 1'b0) begin
         fails++;
         $display("FAIL impulse_tap0: lat=%0d busy_after_start=%0d value=%0d busy=%b, want 9 8 1 0",
                  lat, bn, $signed(o_value), o_busy);
      end
      tick();
      tests++;
      if (o_valid !== 1'b0 || o_value !== 20'd1) begin
         fails++;
         $display("FAIL impulse_valid_width: valid=%b value=%0d, want 0 and held 1", o_valid, $signed(o_value));
      end
      i_taps = '0;
      i_taps[71:64] = 8'd1;
      start_pulse();
      wait_valid(20, lat, bn);
      tests++;
      if (lat !== 9 || o_value !== 20'd9) begin
         fails++;
         $display("FAIL impulse_tap8: lat=%0d value=%0d, want lat=9 value=9", lat, $signed(o_value));
      end
      tick();
   endtask

   task automatic test_worst_case();
      int lat, bn;
      logic [ACC-1:0] exp_neg;
      exp_neg = 20'(-146304);
      i_taps = fill(8'h80);
      i_coeffs = fill(8'h80);
      start_pulse();
      wait_valid(20, lat, bn);
      tests++;
      if (lat !== 9 || o_value !== 20'd147456) begin
         fails++;
         $display("FAIL worst_pos: lat=%0d value=%0d, want lat=9 value=147456", lat, $signed(o_value));
      end
      i_coeffs = fill(8'd127);
      start_pulse();
      wait_valid(20, lat, bn);
      tests++;
      if (lat !== 9 || o_value !== exp_neg) begin
         fails++;
         $display("FAIL worst_neg: lat=%0d value=%0d, want lat=9 value=-146304", lat, $signed(o_value));
      end
      tick();
   endtask

   task automatic test_snapshot();
      int lat, bn;
      i_coeffs = ramp(1);
      i_taps = ramp(0);
      start_pulse();
      i_taps = fill(8'd5);
      wait_valid(20, lat, bn);
      tests++;
      // sum k*(k+1), k=0..8 = 240; live taps would give 225
      if (lat !== 9 || o_value !== 20'd240) begin
         fails++;
         $display("FAIL snapshot: lat=%0d value=%0d, want lat=9 value=240", lat, $signed(o_value));
      end
      tick();
   endtask

   task automatic test_overrun();
      int lat, bn, extra;
      i_taps = fill(8'd1);
      i_coeffs = fill(8'd1);
      tests++;
      if (o_overrun !== 1'b0) begin
         fails++;
         $display("FAIL overrun_initial: overrun=%b, want 0", o_overrun);
      end
      start_pulse();
      tick();
      tick();
      start_pulse();
      tests++;
      if (o_overrun !== 1'b1) begin
         fails++;
         $display("FAIL overrun_set: overrun=%b, want 1", o_overrun);
      end
      wait_valid(20, lat, bn);
      tests++;
      if (lat !== 6 || o_value !== 20'd9) begin
         fails++;
         $display("FAIL overrun_result: lat_after_second=%0d value=%0d, want 6 and 9", lat, $signed(o_value));
      end
      extra = 0;
      for (int c = 0; c < 15; c++) begin
         tick();
         if (o_valid) extra++;
      end
      tests++;
      if (extra !== 0 || o_overrun !== 1'b1 || o_busy !== 1'b0) begin
         fails++;
         $display("FAIL overrun_sticky: extra_valids=%0d overrun=%b busy=%b, want 0 1 0",
                  extra, o_overrun, o_busy);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tests++;
      if (o_overrun !== 1'b0) begin
         fails++;
         $display("FAIL overrun_clear: overrun=%b, want 0", o_overrun);
      end
   endtask

   task automatic test_back_to_back();
      int lat, bn;
      i_taps = fill(8'd1);
      i_coeffs = fill(8'd1);
      start_pulse();
      wait_valid(20, lat, bn);
      tests++;
      if (lat !== 9 || o_value !== 20'd9) begin
         fails++;
         $display("FAIL b2b_first: lat=%0d value=%0d, want 9 and 9", lat, $signed(o_value));
      end
      i_taps = fill(8'd2);
      start_pulse();
      wait_valid(20, lat, bn);
      tests++;
      if (lat !== 9 || o_value !== 20'd18 || o_overrun !== 1'b0) begin
         fails++;
         $display("FAIL b2b_second: lat=%0d value=%0d overrun=%b, want 9 18 0",
                  lat, $signed(o_value), o_overrun);
      end
      tick();
   endtask

   task automatic test_reset_abort();
      int lat, bn, seen;
      i_taps = fill(8'd3);
      i_coeffs = fill(8'd1);
      start_pulse();
      repeat (4) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      seen = 0;
      for (int c = 0; c < 12; c++) begin
         if (o_valid || o_busy || o_value !== '0) seen++;
         tick();
      end
      tests++;
      if (seen !== 0) begin
         fails++;
         $display("FAIL abort_quiet: cycles_with_activity=%0d value=%0d, want 0 and 0", seen, $signed(o_value));
      end
      start_pulse();
      wait_valid(20, lat, bn);
      tests++;
      if (lat !== 9 || o_value !== 20'd27) begin
         fails++;
         $display("FAIL abort_restart: lat=%0d value=%0d, want 9 and 27", lat, $signed(o_value));
      end
      tick();
   endtask

   initial begin
      reset = 1'b1;
      i_start_calc = 1'b0;
      i_taps = '0;
      i_coeffs = '0;
      test_reset();
      test_impulse();
      test_worst_case();
      test_snapshot();
      test_overrun();
      test_back_to_back();
      test_reset_abort();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
